// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the write-back arbiter: register-file select,
// register-zero constant and the ALU codes that identify long-latency FP ops.
package wb_arbiter_pkg;

    typedef enum logic {
        RF_INT = 1'b0,
        RF_FP  = 1'b1
    } rf_sel_e;

    localparam int REG_ZERO = 0;

    // Decode's ALU control codes for the ops routed to the long-latency FP unit.
    localparam logic [3:0] ALU_FP_ADD = 4'd9;
    localparam logic [3:0] ALU_FP_MUL = 4'd10;

endpackage

// File: rtl/wb_arbiter_if.sv
// Bundle of MEM/WB slot, long-latency FP result handshake and both
// register-file write ports seen by the write-back arbiter.
interface wb_arbiter_if #(
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int DEPTH = 2
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          wb_valid;
    logic          wb_fp;
    logic          wb_reg_write;
    logic          wb_mem_to_reg;
    logic [AW-1:0] wb_rd;
    logic [DW-1:0] wb_alu_result;
    logic [DW-1:0] wb_mem_rdata;

    // fpl handshake: a result transfers on any clock edge where fpl_valid and
    // fpl_ready are both high; the producer holds fpl_* stable until then, and
    // fpl_ready never depends combinationally on fpl_valid.
    logic          fpl_valid;
    logic [AW-1:0] fpl_rd;
    logic [DW-1:0] fpl_result;
    logic          fpl_ready;

    logic          int_we;
    logic [AW-1:0] int_waddr;
    logic [DW-1:0] int_wdata;
    logic          fp_we;
    logic [AW-1:0] fp_waddr;
    logic [DW-1:0] fp_wdata;
    logic [CW-1:0] pend_cnt;

    modport master (
        output wb_valid, wb_fp, wb_reg_write, wb_mem_to_reg, wb_rd,
               wb_alu_result, wb_mem_rdata, fpl_valid, fpl_rd, fpl_result,
        input  fpl_ready, int_we, int_waddr, int_wdata, fp_we, fp_waddr,
               fp_wdata, pend_cnt
    );

    modport slave (
        input  wb_valid, wb_fp, wb_reg_write, wb_mem_to_reg, wb_rd,
               wb_alu_result, wb_mem_rdata, fpl_valid, fpl_rd, fpl_result,
        output fpl_ready, int_we, int_waddr, int_wdata, fp_we, fp_waddr,
               fp_wdata, pend_cnt
    );

endinterface

// File: rtl/wb_fp_fifo.sv
// Small FIFO of long-latency FP results; each entry carries a valid bit that a
// younger pipeline write to the same register can clear in place.
module wb_fp_fifo #(
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic [AW-1:0]            push_rd,
    input  logic [DW-1:0]            push_data,
    input  logic                     push_valid,
    input  logic                     pop,
    input  logic                     kill_en,
    input  logic [AW-1:0]            kill_addr,
    output logic                     head_valid,
    output logic [AW-1:0]            head_rd,
    output logic [DW-1:0]            head_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);

    logic [AW-1:0]    rd_q   [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    assign head_valid = valid_q[rd_ptr];
    assign head_rd    = rd_q[rd_ptr];
    assign head_data  = data_q[rd_ptr];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]   <= '0;
                data_q[i] <= '0;
            end
        end else begin
            // Killed entries keep their slot; only the valid bit drops.
            for (int i = 0; i < DEPTH; i++) begin
                if (kill_en && (rd_q[i] == kill_addr)) begin
                    valid_q[i] <= 1'b0;
                end
            end
            if (push) begin
                rd_q[wr_ptr]    <= push_rd;
                data_q[wr_ptr]  <= push_data;
                valid_q[wr_ptr] <= push_valid;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: registers the integer write port and arbitrates the FP
// write port between the pipeline, buffered long-latency results and bypass.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rstn,
    wb_arbiter_if.slave  bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    rf_sel_e       wb_dest;
    logic          pw;
    logic          pfw;
    logic          accept;
    logic          bypass;
    logic          push;
    logic          push_valid;
    logic          pop;
    logic [DW-1:0] wb_data;

    logic          head_valid;
    logic [AW-1:0] head_rd;
    logic [DW-1:0] head_data;
    logic [CW-1:0] count;

    logic          fp_we_d;
    logic [AW-1:0] fp_waddr_d;
    logic [DW-1:0] fp_wdata_d;

    assign wb_dest = rf_sel_e'(bus.wb_fp);
    assign pw      = bus.wb_valid & bus.wb_reg_write;
    assign pfw     = pw & (wb_dest == RF_FP);
    assign wb_data = bus.wb_mem_to_reg ? bus.wb_mem_rdata : bus.wb_alu_result;

    assign bus.fpl_ready = (count < CW'(DEPTH));
    assign bus.pend_cnt  = count;

    assign accept = bus.fpl_valid & bus.fpl_ready;
    assign pop    = (count != '0) & ~pfw;
    assign bypass = accept & (count == '0) & ~pfw;
    assign push   = accept & ~bypass;
    // A result arriving alongside a pipeline write to the same register is older.
    assign push_valid = ~(pfw & (bus.fpl_rd == bus.wb_rd));

    wb_fp_fifo #(
        .DW    (DW),
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rstn       (rstn),
        .push       (push),
        .push_rd    (bus.fpl_rd),
        .push_data  (bus.fpl_result),
        .push_valid (push_valid),
        .pop        (pop),
        .kill_en    (pfw),
        .kill_addr  (bus.wb_rd),
        .head_valid (head_valid),
        .head_rd    (head_rd),
        .head_data  (head_data),
        .count      (count)
    );

    always_comb begin
        fp_we_d    = 1'b0;
        fp_waddr_d = '0;
        fp_wdata_d = '0;
        if (pfw) begin
            fp_we_d    = 1'b1;
            fp_waddr_d = bus.wb_rd;
            fp_wdata_d = wb_data;
        end else if (pop) begin
            fp_we_d    = head_valid;
            fp_waddr_d = head_rd;
            fp_wdata_d = head_data;
        end else if (bypass) begin
            fp_we_d    = 1'b1;
            fp_waddr_d = bus.fpl_rd;
            fp_wdata_d = bus.fpl_result;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bus.int_we    <= 1'b0;
            bus.int_waddr <= '0;
            bus.int_wdata <= '0;
            bus.fp_we     <= 1'b0;
            bus.fp_waddr  <= '0;
            bus.fp_wdata  <= '0;
        end else begin
            bus.int_we    <= pw & (wb_dest == RF_INT) & (bus.wb_rd != AW'(REG_ZERO));
            bus.int_waddr <= bus.wb_rd;
            bus.int_wdata <= wb_data;
            bus.fp_we     <= fp_we_d;
            bus.fp_waddr  <= fp_waddr_d;
            bus.fp_wdata  <= fp_wdata_d;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios then random traffic, all checked
// against a queue-based reference of the write-back rules.
module tb_wb_arbiter;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 2;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    wb_arbiter_if #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) bus ();

    wb_arbiter #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference buffer entries are {valid, rd, data}; producer entries {rd, data}.
    logic [AW+DW:0]   exp_q[$];
    logic [AW+DW-1:0] prod_q[$];

    logic          e_int_we;
    logic [AW-1:0] e_int_waddr;
    logic [DW-1:0] e_int_wdata;
    logic          e_fp_we;
    logic [AW-1:0] e_fp_waddr;
    logic [DW-1:0] e_fp_wdata;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic drive_idle_inputs();
        bus.wb_valid      = 1'b0;
        bus.wb_fp         = 1'b0;
        bus.wb_reg_write  = 1'b0;
        bus.wb_mem_to_reg = 1'b0;
        bus.wb_rd         = '0;
        bus.wb_alu_result = '0;
        bus.wb_mem_rdata  = '0;
        bus.fpl_valid     = 1'b0;
        bus.fpl_rd        = '0;
        bus.fpl_result    = '0;
    endtask

    // One clock: drive inputs, predict, clock, then compare registered outputs.
    task automatic step(input logic v, input logic fp, input logic rw, input logic m2r,
                        input logic [AW-1:0] rd, input logic [DW-1:0] alu,
                        input logic [DW-1:0] mem);
        logic [AW+DW-1:0] p;
        logic [AW+DW:0]   e;
        logic [DW-1:0]    sel;
        logic             pfw;
        logic             ready;
        logic             accept;
        int               n0;
        bus.wb_valid      = v;
        bus.wb_fp         = fp;
        bus.wb_reg_write  = rw;
        bus.wb_mem_to_reg = m2r;
        bus.wb_rd         = rd;
        bus.wb_alu_result = alu;
        bus.wb_mem_rdata  = mem;
        p = '0;
        if (prod_q.size() > 0) p = prod_q[0];
        bus.fpl_valid  = (prod_q.size() > 0);
        bus.fpl_rd     = p[AW+DW-1:DW];
        bus.fpl_result = p[DW-1:0];

        n0     = exp_q.size();
        ready  = (n0 < DEPTH);
        check("fpl_ready", bus.fpl_ready, ready);
        check("pend_cnt", bus.pend_cnt, n0);

        sel    = m2r ? mem : alu;
        pfw    = v & rw & fp;
        accept = bus.fpl_valid & ready;
        e_int_we    = v & rw & ~fp & (rd != 0);
        e_int_waddr = rd;
        e_int_wdata = sel;
        e_fp_we     = 1'b0;
        e_fp_waddr  = '0;
        e_fp_wdata  = '0;
        if (pfw) begin
            e_fp_we    = 1'b1;
            e_fp_waddr = rd;
            e_fp_wdata = sel;
            for (int i = 0; i < exp_q.size(); i++) begin
                e = exp_q[i];
                if (e[AW+DW-1:DW] == rd) e[AW+DW] = 1'b0;
                exp_q[i] = e;
            end
        end else if (n0 > 0) begin
            e = exp_q.pop_front();
            e_fp_we    = e[AW+DW];
            e_fp_waddr = e[AW+DW-1:DW];
            e_fp_wdata = e[DW-1:0];
        end else if (accept) begin
            e_fp_we    = 1'b1;
            e_fp_waddr = p[AW+DW-1:DW];
            e_fp_wdata = p[DW-1:0];
        end
        if (accept) begin
            if (pfw || n0 > 0) begin
                exp_q.push_back({!(pfw && p[AW+DW-1:DW] == rd), p});
            end
            void'(prod_q.pop_front());
        end

        @(posedge clk);
        #1;
        check("int_we", bus.int_we, e_int_we);
        if (e_int_we) begin
            check("int_waddr", bus.int_waddr, e_int_waddr);
            check("int_wdata", bus.int_wdata, e_int_wdata);
        end
        check("fp_we", bus.fp_we, e_fp_we);
        if (e_fp_we) begin
            check("fp_waddr", bus.fp_waddr, e_fp_waddr);
            check("fp_wdata", bus.fp_wdata, e_fp_wdata);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    initial begin
        drive_idle_inputs();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_int_we", bus.int_we, 0);
        check("rst_int_wdata", bus.int_wdata, 0);
        check("rst_fp_we", bus.fp_we, 0);
        check("rst_fp_waddr", bus.fp_waddr, 0);
        check("rst_pend_cnt", bus.pend_cnt, 0);
        check("rst_fpl_ready", bus.fpl_ready, 1);
        rstn = 1'b1;
        idle(1);

        // Integer ALU write, then the same write aimed at $0.
        step(1, 0, 1, 0, 5'd8, 32'h0000_0005, 32'h0);
        step(1, 0, 1, 0, 5'd0, 32'h0000_0005, 32'h0);
        // Load select, integer then FP destination.
        step(1, 0, 1, 1, 5'd9, 32'h0, 32'hDEAD_BEEF);
        step(1, 1, 1, 1, 5'd4, 32'h0, 32'hDEAD_BEEF);
        idle(1);

        // Collision: pipeline f2 and long-latency f6 together.
        prod_q.push_back({5'd6, 32'h4040_0000});
        step(1, 1, 1, 0, 5'd2, 32'h3F80_0000, 32'h0);
        idle(2);

        // Fill the buffer behind four pipeline FP writes.
        prod_q.push_back({5'd1, 32'hA000_0001});
        prod_q.push_back({5'd2, 32'hA000_0002});
        prod_q.push_back({5'd3, 32'hA000_0003});
        for (int i = 0; i < 4; i++) step(1, 1, 1, 0, 5'd10, 32'hB000_0000 + i, 32'h0);
        idle(5);

        // Squash of a buffered f5 by a younger pipeline write.
        prod_q.push_back({5'd5, 32'h5555_5555});
        step(1, 1, 1, 0, 5'd12, 32'hC000_0000, 32'h0);
        step(1, 1, 1, 0, 5'd5, 32'h1111_1111, 32'h0);
        idle(2);
        // Squash of an f5 accepted in the same cycle as the pipeline write.
        prod_q.push_back({5'd5, 32'h6666_6666});
        step(1, 1, 1, 0, 5'd5, 32'h2222_2222, 32'h0);
        idle(2);

        // Reset while two results are pending.
        prod_q.push_back({5'd7, 32'h7777_7777});
        prod_q.push_back({5'd8, 32'h8888_8888});
        step(1, 1, 1, 0, 5'd20, 32'hD000_0000, 32'h0);
        step(1, 1, 1, 0, 5'd21, 32'hD000_0001, 32'h0);
        check("pre_rst_pend_cnt", bus.pend_cnt, exp_q.size());
        rstn = 1'b0;
        #1;
        check("mid_rst_fp_we", bus.fp_we, 0);
        check("mid_rst_pend_cnt", bus.pend_cnt, 0);
        check("mid_rst_fpl_ready", bus.fpl_ready, 1);
        exp_q.delete();
        prod_q.delete();
        drive_idle_inputs();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        idle(3);

        // Random traffic with a narrow register range to provoke collisions.
        for (int c = 0; c < 600; c++) begin
            if (prod_q.size() == 0 && $urandom_range(0, 1) == 0) begin
                prod_q.push_back({5'($urandom_range(0, 7)), 32'($urandom)});
            end
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 7)), 32'($urandom), 32'($urandom));
        end
        prod_q.delete();
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
